// File: rtl/vga_timing_ctrl_if.sv
// rtl/vga_timing_ctrl_if.sv - pixel request/return handshake between the timing controller and the pattern source
interface vga_timing_ctrl_if #(
  parameter int DATA_W = 30
);
  logic              pix_req;
  logic [9:0]        pix_x;
  logic [9:0]        pix_y;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;

  modport master (output pix_req, pix_x, pix_y, input pix_data, pix_valid);
  modport slave  (input pix_req, pix_x, pix_y, output pix_data, pix_valid);
endinterface

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster timing, pixel request sequencing and DAC-side output stage
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int DATA_W   = 30
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                en,
  vga_timing_ctrl_if.master   pix,
  output logic [DATA_W-1:0]   data_to_screen,
  output logic                HSYNC,
  output logic                FSYNC,
  output logic                BLANK,
  output logic                SYNC,
  output logic                frame_start,
  output logic                underflow,
  input  logic                clr_underflow
);

  localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        h_last;
  logic        v_last;
  logic        running;
  logic        active_c;
  logic        hsync_c;
  logic        vsync_c;
  logic        pix_req_c;
  logic        act_d;

  assign h_last   = (h_cnt == H_LAST);
  assign v_last   = (v_cnt == V_LAST);
  assign running  = (state != IDLE);
  assign active_c = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hsync_c  = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
  assign vsync_c  = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A stop request only takes effect on the last pixel of a frame, so a frame is never cut short.
  always_comb begin
    state_nxt = state;
    pix_req_c = 1'b0;
    case (state)
      IDLE:     if (en) state_nxt = RUN;
      RUN:      if (!en) state_nxt = STOPPING;
      STOPPING: begin
        if (en) begin
          state_nxt = RUN;
        end else if (h_last && v_last) begin
          state_nxt = IDLE;
        end
      end
      default:  state_nxt = IDLE;
    endcase
    pix_req_c = running && active_c;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !running) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  assign pix.pix_req = pix_req_c;
  assign pix.pix_x   = running ? h_cnt[9:0] : 10'd0;
  assign pix.pix_y   = running ? v_cnt[9:0] : 10'd0;

  // Output stage lags the counters by one cycle so it lines up with the returned pixel.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      act_d       <= 1'b0;
      HSYNC       <= 1'b1;
      FSYNC       <= 1'b1;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      act_d       <= pix_req_c;
      HSYNC       <= running ? hsync_c : 1'b1;
      FSYNC       <= running ? vsync_c : 1'b1;
      frame_start <= running && (h_cnt == 12'd0) && (v_cnt == 12'd0);
      if (act_d && !pix.pix_valid) begin
        underflow <= 1'b1;
      end else if (clr_underflow) begin
        underflow <= 1'b0;
      end
    end
  end

  assign BLANK          = act_d;
  assign SYNC           = 1'b0;
  assign data_to_screen = (act_d && pix.pix_valid) ? pix.pix_data : '0;

endmodule
